// File: rtl/gat_evt_trace.sv
// gat_evt_trace
//   Event trace buffer for the pipeline debug tap. Rising edges of the
//   per-stage valid/ready strobes are stamped with a free-running capture
//   timestamp and pushed into a circular FIFO. A host drains the FIFO through
//   a one-request/one-response read port.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   evt_i        raw event levels, MSB first: spmm_vld, spmm_rdy, dmvm_vld,
//                dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy
//   arm_i        start capture (strobe, only honoured in IDLE)
//   clr_i        synchronous clear of FIFO state, counters and FSM
//   rd_req_i     pop request
//   rd_vld_o     one-cycle pulse, rd_data_o holds the popped entry
//   rd_data_o    {timestamp, event mask}
//   count_o      entries held
//   ovf_o        sticky, at least one entry was dropped
//   drop_cnt_o   dropped entries, saturating
//   state_o      0 IDLE, 1 ARMED, 2 FULL

// Per-event rising-edge detector. The previous level tracks the input in
// every state, so a level already high at arm time never looks like a rise.
module gat_evt_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic evt_i,
   output logic rise_o
);
   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = evt_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= prev_d;
   end

   assign rise_o = evt_i & ~prev_q;
endmodule

module gat_evt_trace #(
   parameter int NUM_EVT = 8,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_EVT-1:0]         evt_i,
   input  logic                       arm_i,
   input  logic                       clr_i,
   input  logic                       rd_req_i,
   output logic                       rd_vld_o,
   output logic [TS_W+NUM_EVT-1:0]    rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o,
   output logic [15:0]                drop_cnt_o,
   output logic [1:0]                 state_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TS_W + NUM_EVT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              rd_vld_q, rd_vld_d;
   logic [EW-1:0]     rd_data_q, rd_data_d;
   logic [EW-1:0]     mem_q [DEPTH];

   logic [NUM_EVT-1:0] rise;
   logic               any_rise;
   logic               wr_en;
   logic               pop;

   for (genvar i = 0; i < NUM_EVT; i++) begin : g_lane
      gat_evt_edge u_edge (
         .clk    (clk),
         .rst_n  (rst_n),
         .evt_i  (evt_i[i]),
         .rise_o (rise[i])
      );
   end

   assign any_rise = |rise;

   always_comb begin
      state_d    = state_q;
      ts_d       = ts_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      rd_vld_d   = 1'b0;
      rd_data_d  = rd_data_q;
      wr_en      = 1'b0;
      pop        = 1'b0;

      if (clr_i) begin
         // Storage is left as is; only bookkeeping is reset.
         state_d    = ST_IDLE;
         ts_d       = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end else begin
         // Pop qualifies on the count held before this edge, so a write into
         // an empty FIFO cannot be popped in the same cycle.
         pop   = rd_req_i && (count_q != '0);
         wr_en = (state_q == ST_ARMED) && any_rise;

         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_vld_d  = 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
         end
         count_d = count_q + CW'(wr_en) - CW'(pop);

         unique case (state_q)
            ST_IDLE: begin
               if (arm_i) begin
                  state_d = ST_ARMED;
                  ts_d    = '0;
               end
            end
            ST_ARMED: begin
               ts_d = ts_q + 1'b1;
               if (count_d == CW'(DEPTH)) state_d = ST_FULL;
            end
            ST_FULL: begin
               ts_d = ts_q + 1'b1;
               // A rise while full is lost even if a pop frees a slot now.
               if (any_rise) begin
                  ovf_d = 1'b1;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               end
               if (pop) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
         rd_vld_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
         rd_vld_q   <= rd_vld_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Entry records the timestamp held before the capturing edge.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {ts_q, rise};
   end

   assign rd_vld_o   = rd_vld_q;
   assign rd_data_o  = rd_data_q;
   assign count_o    = count_q;
   assign ovf_o      = ovf_q;
   assign drop_cnt_o = drop_cnt_q;
   assign state_o    = state_q;
endmodule

// File: tb/tb_gat_evt_trace.sv
// Scoreboard bench for gat_evt_trace: expected read data is queued when a
// read is issued and compared by an independent monitor on rd_vld_o.
module tb_gat_evt_trace;
   localparam int NUM_EVT = 8;
   localparam int DEPTH   = 16;
   localparam int TS_W    = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  evt_i = '0;
   logic        arm_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        rd_req_i = 1'b0;
   logic        rd_vld_o;
   logic [31:0] rd_data_o;
   logic [4:0]  count_o;
   logic        ovf_o;
   logic [15:0] drop_cnt_o;
   logic [1:0]  state_o;

   int          nchk = 0;
   int          nerr = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;
   logic [31:0] e;

   gat_evt_trace #(.NUM_EVT(NUM_EVT), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .evt_i      (evt_i),
      .arm_i      (arm_i),
      .clr_i      (clr_i),
      .rd_req_i   (rd_req_i),
      .rd_vld_o   (rd_vld_o),
      .rd_data_o  (rd_data_o),
      .count_o    (count_o),
      .ovf_o      (ovf_o),
      .drop_cnt_o (drop_cnt_o),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_vld_o) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL rd_unexpected: got %0h expected no response", rd_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rd_data", rd_data_o, mon_e);
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic rearm(input logic [7:0] v);
      clr_i = 1'b1; evt_i = v; step();
      clr_i = 1'b0; arm_i = 1'b1; step();
      arm_i = 1'b0;
   endtask

   task automatic rd(input logic [31:0] x);
      exp_q.push_back(x);
      rd_req_i = 1'b1; step();
      rd_req_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      chk("rst_rd_vld", rd_vld_o, 0);
      chk("rst_rd_data", rd_data_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      chk("rst_state", state_o, 0);
      rst_n = 1'b1; step();

      // Arm at A, rise sampled at A+5 -> ts 4
      arm_i = 1'b1; step(); arm_i = 1'b0;
      repeat (4) step();
      evt_i = 8'h01; step();
      chk("t1_count", count_o, 1);
      chk("t1_state", state_o, 1);
      rd({24'd4, 8'h01});
      chk("t1_count_after_rd", count_o, 0);

      // Simultaneous rises share one entry
      rearm(8'h00);
      evt_i = 8'h84; step();
      chk("t2_count", count_o, 1);
      rd({24'd0, 8'h84});

      // Level high before arm is not captured until it re-rises
      rearm(8'h08);
      repeat (5) step();
      chk("t3_no_entry", count_o, 0);
      evt_i = 8'h00; repeat (5) step();
      evt_i = 8'h08; step();
      chk("t3_count", count_o, 1);
      rd({24'd10, 8'h08});

      // 20 rises, no reads: 16 kept, 4 dropped
      rearm(8'h00);
      for (int i = 0; i < 20; i++) begin
         evt_i = 8'h01; step();
         evt_i = 8'h00; step();
      end
      chk("t4_state_full", state_o, 2);
      chk("t4_count", count_o, 16);
      chk("t4_ovf", ovf_o, 1);
      chk("t4_drop", drop_cnt_o, 4);
      rd({24'd0, 8'h01});
      chk("t4_state_armed", state_o, 1);
      chk("t4_count_15", count_o, 15);
      evt_i = 8'h01; step();
      chk("t4_count_refill", count_o, 16);
      chk("t4_state_refull", state_o, 2);
      for (int j = 1; j <= 16; j++) begin
         e = (j < 16) ? {24'(2 * j), 8'h01} : {24'd41, 8'h01};
         exp_q.push_back(e);
         rd_req_i = 1'b1; step();
      end
      rd_req_i = 1'b0;
      chk("t4_drained", count_o, 0);
      chk("t4_state_end", state_o, 1);

      // Streaming write+pop at count 5 across pointer wrap
      rearm(8'h00);
      for (int i = 0; i < 5; i++) begin
         evt_i = 8'h01; step();
         if (i < 4) begin evt_i = 8'h00; step(); end
      end
      chk("t5_count5", count_o, 5);
      for (int j = 0; j < 45; j++) begin
         if (j < 40) evt_i = (j % 2 == 0) ? 8'h02 : 8'h01;
         if (j < 5) e = {24'(2 * j), 8'h01};
         else       e = {24'(j + 4), ((j + 5) % 2 == 0) ? 8'h02 : 8'h01};
         exp_q.push_back(e);
         rd_req_i = 1'b1; step();
         if (j < 40) chk("t5_count_stream", count_o, 5);
      end
      rd_req_i = 1'b0;
      chk("t5_drained", count_o, 0);

      // clr with arm and rd_req while FULL
      rearm(8'h00);
      for (int i = 0; i < 17; i++) begin
         evt_i = 8'h01; step();
         evt_i = 8'h00; step();
      end
      chk("t6_full", state_o, 2);
      chk("t6_drop", drop_cnt_o, 1);
      clr_i = 1'b1; arm_i = 1'b1; rd_req_i = 1'b1; evt_i = 8'h01; step();
      clr_i = 1'b0; arm_i = 1'b0; rd_req_i = 1'b0;
      chk("t6_state", state_o, 0);
      chk("t6_count", count_o, 0);
      chk("t6_ovf", ovf_o, 0);
      chk("t6_drop0", drop_cnt_o, 0);
      chk("t6_rd_vld", rd_vld_o, 0);

      // Read when empty: no pulse, data holds
      rd_req_i = 1'b1; step(); rd_req_i = 1'b0;
      chk("t7_rd_vld", rd_vld_o, 0);
      chk("t7_rd_hold", rd_data_o, {24'd48, 8'h01});
      // Write and pop on same edge at count 0: write lands, pop rejected
      evt_i = 8'h00; arm_i = 1'b1; step(); arm_i = 1'b0;
      evt_i = 8'h40; rd_req_i = 1'b1; step(); rd_req_i = 1'b0;
      chk("t7_count", count_o, 1);
      chk("t7_rd_vld0", rd_vld_o, 0);
      chk("t7_rd_hold2", rd_data_o, {24'd48, 8'h01});
      rd({24'd0, 8'h40});
      chk("t7_count0", count_o, 0);

      // Asynchronous reset mid-capture
      evt_i = 8'h00; step();
      evt_i = 8'h40; step();
      chk("t8_count_pre", count_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_count", count_o, 0);
      chk("t8_state", state_o, 0);
      chk("t8_rd_data", rd_data_o, 0);
      chk("t8_rd_vld", rd_vld_o, 0);
      step(); rst_n = 1'b1; step();

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
